// File: rtl/id_ex_stage_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg_if
// Bundles the ID-side inputs, the pipeline controls and the EX-side outputs of
// the ID/EX pipeline register.
//   master : driven by the ID stage / pipeline control (drives id_*, hold,
//            flush, stall, cnt_clr; observes ex_* and bubble_cnt)
//   slave  : the id_ex_stage_reg itself (consumes id_* and controls, drives
//            ex_* and bubble_cnt)
// Parameters: DATA_W (PC / operand width), CNT_W (bubble counter width)
// -----------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // pipeline controls
  logic              hold;
  logic              flush;
  logic              stall;
  logic              cnt_clr;

  // ID-side fields
  logic              id_valid;
  logic [3:0]        id_ex_command;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_wb_en;
  logic              id_b;
  logic              id_s;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_val_rn;
  logic [DATA_W-1:0] id_val_rm;
  logic              id_imm;
  logic [11:0]       id_shift_operand;
  logic [23:0]       id_signed_imm_24;
  logic [3:0]        id_dest;
  logic [3:0]        id_src1;
  logic [3:0]        id_src2;

  // EX-side registered copies
  logic              ex_valid;
  logic [3:0]        ex_ex_command;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_wb_en;
  logic              ex_b;
  logic              ex_s;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_val_rn;
  logic [DATA_W-1:0] ex_val_rm;
  logic              ex_imm;
  logic [11:0]       ex_shift_operand;
  logic [23:0]       ex_signed_imm_24;
  logic [3:0]        ex_dest;
  logic [3:0]        ex_src1;
  logic [3:0]        ex_src2;

  // performance observation
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output hold, flush, stall, cnt_clr,
    output id_valid, id_ex_command, id_mem_read, id_mem_write, id_wb_en,
    output id_b, id_s, id_pc, id_val_rn, id_val_rm, id_imm,
    output id_shift_operand, id_signed_imm_24, id_dest, id_src1, id_src2,
    input  ex_valid, ex_ex_command, ex_mem_read, ex_mem_write, ex_wb_en,
    input  ex_b, ex_s, ex_pc, ex_val_rn, ex_val_rm, ex_imm,
    input  ex_shift_operand, ex_signed_imm_24, ex_dest, ex_src1, ex_src2,
    input  bubble_cnt
  );

  modport slave (
    input  hold, flush, stall, cnt_clr,
    input  id_valid, id_ex_command, id_mem_read, id_mem_write, id_wb_en,
    input  id_b, id_s, id_pc, id_val_rn, id_val_rm, id_imm,
    input  id_shift_operand, id_signed_imm_24, id_dest, id_src1, id_src2,
    output ex_valid, ex_ex_command, ex_mem_read, ex_mem_write, ex_wb_en,
    output ex_b, ex_s, ex_pc, ex_val_rn, ex_val_rm, ex_imm,
    output ex_shift_operand, ex_signed_imm_24, ex_dest, ex_src1, ex_src2,
    output bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register. Captures decoded control, operands, immediates and
// register indices from the ID stage every cycle and presents them to EX one
// cycle later. Supports hold (freeze), flush and stall (bubble insertion) and
// keeps a saturating count of inserted bubbles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all outputs and the counter)
//   bus   : id_ex_stage_reg_if.slave - controls, id_* inputs, ex_* outputs,
//           bubble_cnt
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  id_ex_stage_reg_if.slave       bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // stage registers
  logic              r_valid;
  logic [3:0]        r_ex_command;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_wb_en;
  logic              r_b;
  logic              r_s;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_val_rn;
  logic [DATA_W-1:0] r_val_rm;
  logic              r_imm;
  logic [11:0]       r_shift_operand;
  logic [23:0]       r_signed_imm_24;
  logic [3:0]        r_dest;
  logic [3:0]        r_src1;
  logic [3:0]        r_src2;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // next-state values
  logic              w_valid;
  logic [3:0]        w_ex_command;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_wb_en;
  logic              w_b;
  logic              w_s;
  logic [DATA_W-1:0] w_pc;
  logic [DATA_W-1:0] w_val_rn;
  logic [DATA_W-1:0] w_val_rm;
  logic              w_imm;
  logic [11:0]       w_shift_operand;
  logic [23:0]       w_signed_imm_24;
  logic [3:0]        w_dest;
  logic [3:0]        w_src1;
  logic [3:0]        w_src2;
  logic [CNT_W-1:0]  w_bubble_cnt;

  logic              w_bubble;

  // flush and stall both inject the same bubble and are counted once together
  assign w_bubble = bus.flush | bus.stall;

  // Next payload selection: hold > bubble (flush/stall) > normal capture
  always_comb begin
    w_valid         = r_valid;
    w_ex_command    = r_ex_command;
    w_mem_read      = r_mem_read;
    w_mem_write     = r_mem_write;
    w_wb_en         = r_wb_en;
    w_b             = r_b;
    w_s             = r_s;
    w_pc            = r_pc;
    w_val_rn        = r_val_rn;
    w_val_rm        = r_val_rm;
    w_imm           = r_imm;
    w_shift_operand = r_shift_operand;
    w_signed_imm_24 = r_signed_imm_24;
    w_dest          = r_dest;
    w_src1          = r_src1;
    w_src2          = r_src2;
    if (bus.hold) begin
      // freeze: keep every register
      w_valid = r_valid;
    end else if (w_bubble) begin
      // fully zeroed bubble so forwarding compares see deterministic indices
      w_valid         = 1'b0;
      w_ex_command    = 4'b0000;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_wb_en         = 1'b0;
      w_b             = 1'b0;
      w_s             = 1'b0;
      w_pc            = {DATA_W{1'b0}};
      w_val_rn        = {DATA_W{1'b0}};
      w_val_rm        = {DATA_W{1'b0}};
      w_imm           = 1'b0;
      w_shift_operand = 12'h000;
      w_signed_imm_24 = 24'h000000;
      w_dest          = 4'h0;
      w_src1          = 4'h0;
      w_src2          = 4'h0;
    end else begin
      // data fields are captured regardless of id_valid
      w_pc            = bus.id_pc;
      w_val_rn        = bus.id_val_rn;
      w_val_rm        = bus.id_val_rm;
      w_imm           = bus.id_imm;
      w_shift_operand = bus.id_shift_operand;
      w_signed_imm_24 = bus.id_signed_imm_24;
      w_dest          = bus.id_dest;
      w_src1          = bus.id_src1;
      w_src2          = bus.id_src2;
      if (bus.id_valid) begin
        w_valid      = 1'b1;
        w_ex_command = bus.id_ex_command;
        w_mem_read   = bus.id_mem_read;
        w_mem_write  = bus.id_mem_write;
        w_wb_en      = bus.id_wb_en;
        w_b          = bus.id_b;
        w_s          = bus.id_s;
      end else begin
        // invalid slot: control squashed so it cannot write memory or regs
        w_valid      = 1'b0;
        w_ex_command = 4'b0000;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_wb_en      = 1'b0;
        w_b          = 1'b0;
        w_s          = 1'b0;
      end
    end
  end

  // Bubble counter next value: clear beats increment, saturates at all-ones
  always_comb begin
    w_bubble_cnt = r_bubble_cnt;
    if (bus.hold) begin
      w_bubble_cnt = r_bubble_cnt;
    end else if (bus.cnt_clr) begin
      w_bubble_cnt = {CNT_W{1'b0}};
    end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
      w_bubble_cnt = r_bubble_cnt + CNT_ONE;
    end else begin
      w_bubble_cnt = r_bubble_cnt;
    end
  end

  // Stage and counter registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= 1'b0;
      r_ex_command    <= 4'b0000;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_wb_en         <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_pc            <= {DATA_W{1'b0}};
      r_val_rn        <= {DATA_W{1'b0}};
      r_val_rm        <= {DATA_W{1'b0}};
      r_imm           <= 1'b0;
      r_shift_operand <= 12'h000;
      r_signed_imm_24 <= 24'h000000;
      r_dest          <= 4'h0;
      r_src1          <= 4'h0;
      r_src2          <= 4'h0;
      r_bubble_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_valid         <= w_valid;
      r_ex_command    <= w_ex_command;
      r_mem_read      <= w_mem_read;
      r_mem_write     <= w_mem_write;
      r_wb_en         <= w_wb_en;
      r_b             <= w_b;
      r_s             <= w_s;
      r_pc            <= w_pc;
      r_val_rn        <= w_val_rn;
      r_val_rm        <= w_val_rm;
      r_imm           <= w_imm;
      r_shift_operand <= w_shift_operand;
      r_signed_imm_24 <= w_signed_imm_24;
      r_dest          <= w_dest;
      r_src1          <= w_src1;
      r_src2          <= w_src2;
      r_bubble_cnt    <= w_bubble_cnt;
    end
  end

  assign bus.ex_valid         = r_valid;
  assign bus.ex_ex_command    = r_ex_command;
  assign bus.ex_mem_read      = r_mem_read;
  assign bus.ex_mem_write     = r_mem_write;
  assign bus.ex_wb_en         = r_wb_en;
  assign bus.ex_b             = r_b;
  assign bus.ex_s             = r_s;
  assign bus.ex_pc            = r_pc;
  assign bus.ex_val_rn        = r_val_rn;
  assign bus.ex_val_rm        = r_val_rm;
  assign bus.ex_imm           = r_imm;
  assign bus.ex_shift_operand = r_shift_operand;
  assign bus.ex_signed_imm_24 = r_signed_imm_24;
  assign bus.ex_dest          = r_dest;
  assign bus.ex_src1          = r_src1;
  assign bus.ex_src2          = r_src2;
  assign bus.bubble_cnt       = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed-vector bench for id_ex_stage_reg (DATA_W=32, CNT_W=4 so the counter
// saturates quickly). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  id_ex_stage_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every vector, reports mismatches
  task automatic check_vec(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hold             = 1'b0;
    bus.flush            = 1'b0;
    bus.stall            = 1'b0;
    bus.cnt_clr          = 1'b0;
    bus.id_valid         = 1'b0;
    bus.id_ex_command    = 4'b0000;
    bus.id_mem_read      = 1'b0;
    bus.id_mem_write     = 1'b0;
    bus.id_wb_en         = 1'b0;
    bus.id_b             = 1'b0;
    bus.id_s             = 1'b0;
    bus.id_pc            = 32'h0;
    bus.id_val_rn        = 32'h0;
    bus.id_val_rm        = 32'h0;
    bus.id_imm           = 1'b0;
    bus.id_shift_operand = 12'h000;
    bus.id_signed_imm_24 = 24'h000000;
    bus.id_dest          = 4'h0;
    bus.id_src1          = 4'h0;
    bus.id_src2          = 4'h0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();

    // reset state
    #3;
    check_vec("rst_valid", 64'(bus.ex_valid), 64'h0);
    check_vec("rst_cnt",   64'(bus.bubble_cnt), 64'h0);
    check_vec("rst_pc",    64'(bus.ex_pc), 64'h0);
    #10 rst_n = 1'b1;   // released mid-cycle (t=13)

    // normal capture
    bus.id_valid      = 1'b1;
    bus.id_ex_command = 4'b0100;
    bus.id_pc         = 32'h10;
    bus.id_val_rn     = 32'hA;
    bus.id_val_rm     = 32'h3;
    bus.id_dest       = 4'd2;
    bus.id_wb_en      = 1'b1;
    bus.id_src1       = 4'd5;
    bus.id_src2       = 4'd6;
    step();
    check_vec("cap_pc",    64'(bus.ex_pc), 64'h10);
    check_vec("cap_rn",    64'(bus.ex_val_rn), 64'hA);
    check_vec("cap_rm",    64'(bus.ex_val_rm), 64'h3);
    check_vec("cap_dest",  64'(bus.ex_dest), 64'h2);
    check_vec("cap_wb",    64'(bus.ex_wb_en), 64'h1);
    check_vec("cap_valid", 64'(bus.ex_valid), 64'h1);
    check_vec("cap_cmd",   64'(bus.ex_ex_command), 64'h4);
    check_vec("cap_src",   64'({bus.ex_src1, bus.ex_src2}), 64'h56);

    // one stall so the counter is non-zero before reset
    bus.stall = 1'b1;
    step();
    bus.stall = 1'b0;
    check_vec("stall1_cnt", 64'(bus.bubble_cnt), 64'h1);
    check_vec("stall1_src", 64'({bus.ex_src1, bus.ex_src2}), 64'h0);

    // ADD in flight, then asynchronous reset between edges
    idle_inputs();
    bus.id_valid      = 1'b1;
    bus.id_ex_command = 4'b0010;
    bus.id_wb_en      = 1'b1;
    bus.id_val_rn     = 32'h5;
    step();
    check_vec("add_cmd", 64'(bus.ex_ex_command), 64'h2);
    check_vec("add_rn",  64'(bus.ex_val_rn), 64'h5);
    #2 rst_n = 1'b0;
    #1;
    check_vec("arst_cmd",   64'(bus.ex_ex_command), 64'h0);
    check_vec("arst_rn",    64'(bus.ex_val_rn), 64'h0);
    check_vec("arst_wb",    64'(bus.ex_wb_en), 64'h0);
    check_vec("arst_valid", 64'(bus.ex_valid), 64'h0);
    check_vec("arst_cnt",   64'(bus.bubble_cnt), 64'h0);
    #2 rst_n = 1'b1;

    // stall once (cnt=1), then load LDR
    idle_inputs();
    bus.stall = 1'b1;
    step();
    idle_inputs();
    bus.id_valid    = 1'b1;
    bus.id_mem_read = 1'b1;
    bus.id_wb_en    = 1'b1;
    bus.id_dest     = 4'd4;
    bus.id_pc       = 32'h20;
    step();
    check_vec("ldr_rd",  64'(bus.ex_mem_read), 64'h1);
    check_vec("ldr_cnt", 64'(bus.bubble_cnt), 64'h1);

    // hold for 3 cycles with flush, cnt_clr and changing inputs
    bus.hold    = 1'b1;
    bus.flush   = 1'b1;
    bus.cnt_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc       = 32'h100 + 32'(i);
      bus.id_dest     = 4'(9 + i);
      bus.id_mem_read = 1'b0;
      step();
      check_vec("hold_rd",    64'(bus.ex_mem_read), 64'h1);
      check_vec("hold_wb",    64'(bus.ex_wb_en), 64'h1);
      check_vec("hold_dest",  64'(bus.ex_dest), 64'h4);
      check_vec("hold_pc",    64'(bus.ex_pc), 64'h20);
      check_vec("hold_valid", 64'(bus.ex_valid), 64'h1);
      check_vec("hold_cnt",   64'(bus.bubble_cnt), 64'h1);
    end

    // flush and stall together on a valid STR: one bubble, counted once
    idle_inputs();
    bus.flush        = 1'b1;
    bus.stall        = 1'b1;
    bus.id_valid     = 1'b1;
    bus.id_mem_write = 1'b1;
    bus.id_pc        = 32'h30;
    bus.id_val_rn    = 32'h7;
    bus.id_dest      = 4'd3;
    bus.id_ex_command = 4'b0100;
    step();
    check_vec("fs_mw",    64'(bus.ex_mem_write), 64'h0);
    check_vec("fs_valid", 64'(bus.ex_valid), 64'h0);
    check_vec("fs_pc",    64'(bus.ex_pc), 64'h0);
    check_vec("fs_rn",    64'(bus.ex_val_rn), 64'h0);
    check_vec("fs_dest",  64'(bus.ex_dest), 64'h0);
    check_vec("fs_cmd",   64'(bus.ex_ex_command), 64'h0);
    check_vec("fs_cnt",   64'(bus.bubble_cnt), 64'h2);

    // invalid slot: control squashed, data captured, not counted
    idle_inputs();
    bus.id_valid     = 1'b0;
    bus.id_wb_en     = 1'b1;
    bus.id_mem_write = 1'b1;
    bus.id_pc        = 32'h44;
    bus.id_val_rn    = 32'h8;
    step();
    check_vec("inv_wb",    64'(bus.ex_wb_en), 64'h0);
    check_vec("inv_mw",    64'(bus.ex_mem_write), 64'h0);
    check_vec("inv_valid", 64'(bus.ex_valid), 64'h0);
    check_vec("inv_pc",    64'(bus.ex_pc), 64'h44);
    check_vec("inv_rn",    64'(bus.ex_val_rn), 64'h8);
    check_vec("inv_cnt",   64'(bus.bubble_cnt), 64'h2);

    // saturation: 2 + 13 stalls reaches 4'hF, then stays there
    idle_inputs();
    bus.stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 12) check_vec("sat_reach", 64'(bus.bubble_cnt), 64'hF);
    end
    check_vec("sat_hold", 64'(bus.bubble_cnt), 64'hF);

    // clear beats increment in the same cycle
    bus.cnt_clr = 1'b1;
    step();
    check_vec("clr_cnt", 64'(bus.bubble_cnt), 64'h0);
    bus.cnt_clr = 1'b0;
    step();
    check_vec("post_clr_cnt", 64'(bus.bubble_cnt), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the control unit and register file in the ID stage.
- Captures decoded control (EX_command, mem_read, mem_write, WB_en, B, S), operand values, immediates and register indices each cycle, and presents them to the EX stage.
- Supports three pipeline controls: hold (whole-pipe freeze), flush (taken branch) and stall (hazard bubble).
- Keeps a saturating bubble counter for performance observation.

Parameters:
- DATA_W, 32, width of PC and operand values
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  freeze every register, including the counter
- flush  in  1  taken branch in EX; insert bubble
- stall  in  1  hazard detected in ID; insert bubble
- cnt_clr  in  1  synchronous clear of bubble_cnt
- id_valid  in  1  ID holds a real instruction
- id_ex_command  in  4  EX_command from control unit
- id_mem_read  in  1  memory read
- id_mem_write  in  1  memory write
- id_wb_en  in  1  write-back enable
- id_b  in  1  branch
- id_s  in  1  status update
- id_pc  in  DATA_W  PC+4 of instruction
- id_val_rn  in  DATA_W  Rn value
- id_val_rm  in  DATA_W  Rm value
- id_imm  in  1  immediate flag
- id_shift_operand  in  12  shifter operand field
- id_signed_imm_24  in  24  branch offset
- id_dest  in  4  destination register
- id_src1  in  4  Rn index (forwarding)
- id_src2  in  4  Rm/Rd index (forwarding)
- ex_*  out  same widths as id_*  registered copies; ex_valid out 1 replaces id_valid
- bubble_cnt  out  CNT_W  bubbles inserted since reset/clear

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output, ex_valid and bubble_cnt go to 0 immediately. A reset asserted mid-operation discards the in-flight instruction. Release takes effect at the next rising edge.
- Latency: 1 cycle, ID inputs at edge N appear on ex_* after edge N.
- Priority per rising edge: hold > flush > stall > normal capture.
  - hold=1: all registers keep their value; flush, stall and cnt_clr are ignored that cycle.
  - flush=1 (hold=0): bubble is loaded.
  - stall=1 (flush=0, hold=0): bubble is loaded.
  - Normal: all id_* fields are loaded into ex_*.
- Bubble contents:
  - ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_b and ex_s are all 0.
  - ex_ex_command is 4'b0000.
  - Data and index fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2) are also zeroed, so bubbles are deterministic for forwarding compare.
- id_valid=0 under normal capture: the stage loads as a bubble (all control zero, data captured as-is) and does not count it.
- Counter update, only when hold=0:
  - cnt_clr=1: next value is 0. This takes precedence over an increment in the same cycle.
  - Otherwise, flush or stall: increment by 1, saturating at 2^CNT_W-1 with no wrap.
  - Simultaneous flush and stall count once.
- There is no combinational path from any input to any output.

Test Plan:
- Reset mid-stream: capture ADD (command 4'b0010, wb_en=1, val_rn=32'h5), then assert rst_n=0 between edges -> all ex_* and bubble_cnt read 0 before the next edge.
- Normal capture: id_pc=32'h10, val_rn=32'hA, val_rm=32'h3, dest=4'd2, wb_en=1, id_valid=1 -> the same values appear on ex_* one cycle later, ex_valid=1.
- Hold: load the LDR state (mem_read=1, wb_en=1, dest=4'd4), then hold=1 for 3 cycles with changing inputs and flush=1 -> ex_* unchanged for 3 cycles, bubble_cnt unchanged.
- Flush vs stall: flush=1 and stall=1 in the same cycle with a valid STR input -> ex_mem_write=0, ex_valid=0, all fields 0, bubble_cnt +1 (not +2).
- Counter saturation: with CNT_W=4, apply stall for 20 cycles -> bubble_cnt stops at 4'hF; cnt_clr=1 with stall=1 -> bubble_cnt=0 next cycle.
- Invalid input: id_valid=0 with id_wb_en=1 and id_mem_write=1 -> ex_wb_en=0, ex_mem_write=0, ex_valid=0, bubble_cnt unchanged.
